// File: rtl/axi4_video_stream_checker.sv
// -----------------------------------------------------------------------------
// axi4_video_stream_checker
//
// Sits behind the video test-pattern generator. It checks frame geometry on an
// AXI4-Stream video feed (tuser = start of frame, tlast = end of line), aligns
// the stream to frame boundaries and forwards a well-formed stream through a
// one-stage register slice. Geometry errors are reported as one-cycle pulses,
// and error-free frames are counted.
//
// Optional build macro: AXI4_VIDEO_STREAM_CHECKER_STATS_EN
//   When defined, adds saturating 16-bit error counters (err_*_cnt_o) and a
//   synchronous clear input (stats_clr_i).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   video_i_*             input stream  (tdata/tvalid/tready/tlast/tuser)
//   video_o_*             output stream (tdata/tvalid/tready/tlast/tuser)
//   frame_cnt_o           number of completed good frames (wraps)
//   err_sof_o             pulse: tuser seen mid-frame
//   err_eol_early_o       pulse: tlast before pixel X_ACTIVE-1
//   err_eol_late_o        pulse: no tlast at pixel X_ACTIVE-1
// -----------------------------------------------------------------------------
module axi4_video_stream_checker #(
    parameter int X_ACTIVE    = 1920,
    parameter int Y_ACTIVE    = 1080,
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    input  logic                   video_i_tlast,
    input  logic                   video_i_tuser,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready,
    output logic                   video_o_tlast,
    output logic                   video_o_tuser,
    output logic [15:0]            frame_cnt_o,
    output logic                   err_sof_o,
    output logic                   err_eol_early_o,
    output logic                   err_eol_late_o
`ifdef AXI4_VIDEO_STREAM_CHECKER_STATS_EN
    ,
    input  logic                   stats_clr_i,
    output logic [15:0]            err_sof_cnt_o,
    output logic [15:0]            err_eol_early_cnt_o,
    output logic [15:0]            err_eol_late_cnt_o
`endif
);

    localparam int PX_W = $clog2(X_ACTIVE + 1);
    localparam int LN_W = $clog2(Y_ACTIVE + 1);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(X_ACTIVE - 1);
    localparam logic [LN_W-1:0] LN_LAST = LN_W'(Y_ACTIVE - 1);

    typedef enum logic [1:0] {
        WAIT_SOF  = 2'd0,
        ACTIVE    = 2'd1,
        DROP_TAIL = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [PX_W-1:0]        px_reg, px_next;
    logic [LN_W-1:0]        ln_reg, ln_next;
    logic                   frame_err_reg, frame_err_next;   // error seen in the current frame
    logic                   tail_done_reg, tail_done_next;   // frame already complete while dropping a tail
    logic [15:0]            frame_cnt_reg, frame_cnt_next;
    logic                   err_sof_reg, err_sof_next;
    logic                   err_early_reg, err_early_next;
    logic                   err_late_reg, err_late_next;
    logic [TDATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   out_last_reg, out_last_next;
    logic                   out_user_reg, out_user_next;

    logic slot_free, in_ready, accept;
    logic fwd, fwd_last, fwd_user, start_frame;
    logic is_late, is_early, frame_bad;

    always_comb begin
        slot_free = !out_valid_reg || video_o_tready;
        // Outside ACTIVE only a start-of-frame beat needs the output slot;
        // everything else is dropped and never stalls the source.
        if (state_reg == ACTIVE)
            in_ready = slot_free;
        else
            in_ready = slot_free || !video_i_tuser;
        accept = video_i_tvalid && in_ready;

        state_next     = state_reg;
        px_next        = px_reg;
        ln_next        = ln_reg;
        frame_err_next = frame_err_reg;
        tail_done_next = tail_done_reg;
        frame_cnt_next = frame_cnt_reg;
        err_sof_next   = 1'b0;
        err_early_next = 1'b0;
        err_late_next  = 1'b0;
        fwd            = 1'b0;
        fwd_last       = 1'b0;
        fwd_user       = 1'b0;
        start_frame    = 1'b0;
        is_late        = 1'b0;
        is_early       = 1'b0;
        frame_bad      = 1'b0;

        if (accept) begin
            unique case (state_reg)
                WAIT_SOF: begin
                    start_frame = video_i_tuser;
                end
                DROP_TAIL: begin
                    if (video_i_tuser) begin
                        err_sof_next = 1'b1;
                        start_frame  = 1'b1;
                    end else if (video_i_tlast) begin
                        state_next = tail_done_reg ? WAIT_SOF : ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A mid-frame SOF wins over any end-of-line check.
                    if (video_i_tuser && (px_reg != '0 || ln_reg != '0)) begin
                        err_sof_next = 1'b1;
                        start_frame  = 1'b1;
                    end else begin
                        fwd      = 1'b1;
                        fwd_user = video_i_tuser;
                        is_late  = (px_reg == PX_LAST) && !video_i_tlast;
                        is_early = (px_reg != PX_LAST) && video_i_tlast;
                        if (px_reg == PX_LAST || video_i_tlast) begin
                            fwd_last       = 1'b1;
                            px_next        = '0;
                            err_early_next = is_early;
                            err_late_next  = is_late;
                            frame_bad      = frame_err_reg || is_early || is_late;
                            if (ln_reg == LN_LAST) begin
                                if (!frame_bad)
                                    frame_cnt_next = frame_cnt_reg + 16'd1;
                                ln_next        = '0;
                                frame_err_next = 1'b0;
                                tail_done_next = 1'b1;
                                state_next     = is_late ? DROP_TAIL : WAIT_SOF;
                            end else begin
                                ln_next        = ln_reg + LN_W'(1);
                                frame_err_next = frame_bad;
                                tail_done_next = 1'b0;
                                state_next     = is_late ? DROP_TAIL : ACTIVE;
                            end
                        end else begin
                            px_next = px_reg + PX_W'(1);
                        end
                    end
                end
                default: state_next = WAIT_SOF;
            endcase

            // Every SOF path restarts the frame from this beat.
            if (start_frame) begin
                fwd            = 1'b1;
                fwd_user       = 1'b1;
                fwd_last       = 1'b0;
                px_next        = PX_W'(1);
                ln_next        = '0;
                frame_err_next = 1'b0;
                tail_done_next = 1'b0;
                state_next     = ACTIVE;
            end
        end

        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_user_next  = out_user_reg;
        if (fwd) begin
            out_valid_next = 1'b1;
            out_data_next  = video_i_tdata;
            out_last_next  = fwd_last;
            out_user_next  = fwd_user;
        end else if (video_o_tready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= WAIT_SOF;
            px_reg        <= '0;
            ln_reg        <= '0;
            frame_err_reg <= 1'b0;
            tail_done_reg <= 1'b0;
            frame_cnt_reg <= '0;
            err_sof_reg   <= 1'b0;
            err_early_reg <= 1'b0;
            err_late_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_user_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            px_reg        <= px_next;
            ln_reg        <= ln_next;
            frame_err_reg <= frame_err_next;
            tail_done_reg <= tail_done_next;
            frame_cnt_reg <= frame_cnt_next;
            err_sof_reg   <= err_sof_next;
            err_early_reg <= err_early_next;
            err_late_reg  <= err_late_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_user_reg  <= out_user_next;
        end
    end

    assign video_i_tready  = in_ready;
    assign video_o_tdata   = out_data_reg;
    assign video_o_tvalid  = out_valid_reg;
    assign video_o_tlast   = out_last_reg;
    assign video_o_tuser   = out_user_reg;
    assign frame_cnt_o     = frame_cnt_reg;
    assign err_sof_o       = err_sof_reg;
    assign err_eol_early_o = err_early_reg;
    assign err_eol_late_o  = err_late_reg;

`ifdef AXI4_VIDEO_STREAM_CHECKER_STATS_EN
    // Index 0: SOF, 1: early EOL, 2: late EOL.
    logic [2:0]  stat_pulse;
    logic [15:0] stat_cnt_reg [3];

    assign stat_pulse = {err_late_reg, err_early_reg, err_sof_reg};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                stat_cnt_reg[gi] <= '0;
            else if (stats_clr_i)
                stat_cnt_reg[gi] <= '0;
            else if (stat_pulse[gi] && stat_cnt_reg[gi] != 16'hFFFF)
                stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 16'd1;
        end
    end

    assign err_sof_cnt_o       = stat_cnt_reg[0];
    assign err_eol_early_cnt_o = stat_cnt_reg[1];
    assign err_eol_late_cnt_o  = stat_cnt_reg[2];
`endif

endmodule

// File: tb/tb_axi4_video_stream_checker.sv
// -----------------------------------------------------------------------------
// Testbench for axi4_video_stream_checker (X_ACTIVE=8, Y_ACTIVE=4).
// Frames are described as line lengths plus an optional early cut by the next
// SOF; the expected output stream is derived per line from those lengths and
// queued. A monitor pops one entry each time a new beat appears on video_o.
// -----------------------------------------------------------------------------
module tb_axi4_video_stream_checker;

    localparam int X = 8;
    localparam int Y = 4;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [W-1:0] video_i_tdata = '0;
    logic         video_i_tvalid = 1'b0;
    logic         video_i_tready;
    logic         video_i_tlast = 1'b0;
    logic         video_i_tuser = 1'b0;
    logic [W-1:0] video_o_tdata;
    logic         video_o_tvalid;
    logic         video_o_tready = 1'b0;
    logic         video_o_tlast;
    logic         video_o_tuser;
    logic [15:0]  frame_cnt_o;
    logic         err_sof_o, err_eol_early_o, err_eol_late_o;
`ifdef AXI4_VIDEO_STREAM_CHECKER_STATS_EN
    logic         stats_clr_i = 1'b0;
    logic [15:0]  err_sof_cnt_o, err_eol_early_cnt_o, err_eol_late_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    axi4_video_stream_checker #(.X_ACTIVE(X), .Y_ACTIVE(Y), .TDATA_WIDTH(W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .video_i_tdata   (video_i_tdata),
        .video_i_tvalid  (video_i_tvalid),
        .video_i_tready  (video_i_tready),
        .video_i_tlast   (video_i_tlast),
        .video_i_tuser   (video_i_tuser),
        .video_o_tdata   (video_o_tdata),
        .video_o_tvalid  (video_o_tvalid),
        .video_o_tready  (video_o_tready),
        .video_o_tlast   (video_o_tlast),
        .video_o_tuser   (video_o_tuser),
        .frame_cnt_o     (frame_cnt_o),
        .err_sof_o       (err_sof_o),
        .err_eol_early_o (err_eol_early_o),
        .err_eol_late_o  (err_eol_late_o)
`ifdef AXI4_VIDEO_STREAM_CHECKER_STATS_EN
        ,
        .stats_clr_i         (stats_clr_i),
        .err_sof_cnt_o       (err_sof_cnt_o),
        .err_eol_early_cnt_o (err_eol_early_cnt_o),
        .err_eol_late_cnt_o  (err_eol_late_cnt_o)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         user;
    } beat_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         user;
        logic         sof;
        logic         early;
        logic         late;
        logic [15:0]  cnt;
    } exp_t;

    beat_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0;
    int    ready_pct = 100;
    int    idle_pct = 0;
    bit    hold_ready = 1'b0;
    bit    pending = 1'b0;
    bit    acc_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model / stimulus builders ----------------
    task automatic add_junk(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = $urandom;
            b.last = 1'($urandom_range(1, 0));
            b.user = 1'b0;
            stim_q.push_back(b);
        end
    endtask

    // lens[l]: number of beats in line l, tlast on its final beat.
    // trunc: the frame is cut by the next frame's SOF at line ta, beat tp.
    // sof_err: this frame's SOF arrives mid-frame of the previous one.
    task automatic add_frame(input int lens[Y], input bit trunc, input int ta,
                             input int tp, input bit sof_err);
        beat_t b;
        exp_t  e;
        bit    bad;
        bit    full;
        int    nl;
        int    n_in;
        bad = 1'b0;
        nl  = trunc ? ta + 1 : Y;
        for (int l = 0; l < nl; l++) begin
            full = !(trunc && l == ta);
            n_in = full ? lens[l] : tp;
            for (int i = 0; i < n_in; i++) begin
                b.data = $urandom;
                b.user = (l == 0 && i == 0);
                b.last = full && (i == lens[l] - 1);
                stim_q.push_back(b);
                if (i < X) begin
                    e.data  = b.data;
                    e.user  = b.user;
                    e.sof   = b.user && sof_err;
                    e.last  = 1'b0;
                    e.early = 1'b0;
                    e.late  = 1'b0;
                    if (full && lens[l] < X && i == lens[l] - 1) begin
                        e.last  = 1'b1;
                        e.early = 1'b1;
                        bad     = 1'b1;
                    end
                    if (i == X - 1) begin
                        e.last = 1'b1;
                        if (!(full && lens[l] == X)) begin
                            e.late = 1'b1;
                            bad    = 1'b1;
                        end
                    end
                    if (full && l == Y - 1 && e.last && !bad)
                        exp_frames++;
                    e.cnt = 16'(exp_frames);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic add_clean(input bit sof_err);
        int lens[Y];
        for (int l = 0; l < Y; l++) lens[l] = X;
        add_frame(lens, 1'b0, 0, 0, sof_err);
    endtask

    task automatic add_rand_frame(input bit sof_err, output bit truncated);
        int lens[Y];
        int r, ta, tp;
        bit trunc;
        for (int l = 0; l < Y; l++) begin
            r = int'($urandom_range(99, 0));
            if (r < 70)      lens[l] = X;
            else if (r < 85) lens[l] = int'($urandom_range(X - 1, (l == 0) ? 2 : 1));
            else             lens[l] = int'($urandom_range(X + 3, X + 1));
        end
        trunc = (int'($urandom_range(99, 0)) < 20);
        ta    = int'($urandom_range(Y - 1, 0));
        tp    = (ta == 0) ? int'($urandom_range(lens[0] - 1, 1))
                          : int'($urandom_range(lens[ta] - 1, 0));
        add_frame(lens, trunc, ta, tp, sof_err);
        truncated = trunc;
    endtask

    // ---------------- input driver ----------------
    initial begin
        beat_t b;
        b.data = '0; b.last = 1'b0; b.user = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_i)
                pending = 1'b0;
            else if (pending && acc_seen)
                pending = 1'b0;
            if (!pending && !rst_i && stim_q.size() > 0 &&
                int'($urandom_range(99, 0)) >= idle_pct) begin
                b = stim_q.pop_front();
                pending = 1'b1;
            end
            video_i_tvalid = pending;
            video_i_tdata  = b.data;
            video_i_tlast  = b.last;
            video_i_tuser  = b.user;
        end
    end

    initial forever begin
        @(negedge clk_i);
        acc_seen = video_i_tvalid && video_i_tready;
    end

    initial forever begin
        @(posedge clk_i); #1;
        video_o_tready = !hold_ready && (int'($urandom_range(99, 0)) < ready_pct);
    end

    // ---------------- output monitor ----------------
    initial begin
        bit   prev_valid, prev_ready;
        exp_t cur;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        cur.data = '0; cur.last = 1'b0; cur.user = 1'b0;
        cur.sof = 1'b0; cur.early = 1'b0; cur.late = 1'b0; cur.cnt = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (video_o_tvalid && (!prev_valid || prev_ready)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h, expected no beat", video_o_tdata);
                    end else begin
                        cur = exp_q.pop_front();
                        check("beat_data_last_user", {video_o_tdata, video_o_tlast, video_o_tuser},
                              {cur.data, cur.last, cur.user});
                        check("beat_err_pulses", {err_sof_o, err_eol_early_o, err_eol_late_o},
                              {cur.sof, cur.early, cur.late});
                        check("beat_frame_cnt", frame_cnt_o, cur.cnt);
                    end
                end else begin
                    check("idle_err_pulses", {err_sof_o, err_eol_early_o, err_eol_late_o}, 3'b000);
                    if (video_o_tvalid)
                        check("stall_hold", {video_o_tdata, video_o_tlast, video_o_tuser},
                              {cur.data, cur.last, cur.user});
                end
                prev_valid = video_o_tvalid;
                prev_ready = video_o_tready;
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || pending || exp_q.size() > 0) && n < 5000) begin
            @(posedge clk_i);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check({name, "_frame_cnt"}, frame_cnt_o, 16'(exp_frames));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  lens[Y];
        bit  trunc_prev;
        int  n;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_out_fields", {video_o_tvalid, video_o_tlast, video_o_tuser, video_o_tdata}, '0);
        check("reset_frame_cnt", frame_cnt_o, 16'd0);
        check("reset_err_pulses", {err_sof_o, err_eol_early_o, err_eol_late_o}, 3'b000);
        rst_i = 1'b0;

        // Clean frames.
        add_clean(1'b0);
        add_clean(1'b0);
        wait_drain("clean");

        // Misaligned start: leading beats without SOF are dropped.
        add_junk(5);
        add_clean(1'b0);
        wait_drain("misaligned");

        // Short line 1 (tlast at px 5), then a clean frame.
        for (int l = 0; l < Y; l++) lens[l] = X;
        lens[1] = 6;
        add_frame(lens, 1'b0, 0, 0, 1'b0);
        add_clean(1'b0);
        wait_drain("short_line");

        // Long line 2 (11 px), then a clean frame.
        for (int l = 0; l < Y; l++) lens[l] = X;
        lens[2] = X + 3;
        add_frame(lens, 1'b0, 0, 0, 1'b0);
        add_clean(1'b0);
        wait_drain("long_line");

        // Mid-frame SOF at line 2 px 3.
        for (int l = 0; l < Y; l++) lens[l] = X;
        add_frame(lens, 1'b1, 2, 3, 1'b0);
        add_clean(1'b1);
        wait_drain("mid_sof");

        // Random frames under 50% backpressure and input gaps.
        ready_pct  = 50;
        idle_pct   = 20;
        trunc_prev = 1'b0;
        for (int f = 0; f < 25; f++) begin
            if (!trunc_prev && int'($urandom_range(99, 0)) < 20)
                add_junk(int'($urandom_range(6, 1)));
            add_rand_frame(trunc_prev, trunc_prev);
        end
        if (trunc_prev) add_clean(1'b1);
        wait_drain("random");

        // Reset with a beat stalled in the output slice.
        idle_pct   = 0;
        hold_ready = 1'b1;
        @(posedge clk_i); #2;
        add_clean(1'b0);
        // Only the SOF beat can get through while the output is stalled.
        n = exp_q.size();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_frames = 0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        check("reset_pre_sof_seen", exp_q.size(), 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_pre_held_valid", video_o_tvalid, 1'b1);
        #2;
        rst_i = 1'b1;
        stim_q.delete();
        exp_q.delete();
        #1;
        check("reset_async_fields", {video_o_tvalid, video_o_tlast, video_o_tuser, video_o_tdata}, '0);
        check("reset_async_cnt_err", {frame_cnt_o, err_sof_o, err_eol_early_o, err_eol_late_o}, '0);
        @(posedge clk_i); #1;
        check("reset_next_edge_valid", video_o_tvalid, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i      = 1'b0;
        hold_ready = 1'b0;

        // After reset the next frame is picked up from WAIT_SOF.
        add_junk(3);
        add_clean(1'b0);
        wait_drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
